rx_cmd_decoder: RTL and testbench

// - Downstream of the rx PIE demodulator. Consumes its serial bitout/bitclk stream and
//   its rx_overflow_reset end-of-frame indication.
// - Splits the stream into EPC Gen2 commands and identifies each by its prefix.
// - Captures the command payload and checks CRC5 (Query) or CRC16 (Req_RN).
// - Gives the tag control FSM one pulse per command.

---
 rtl/rx_cmd_decoder_pkg.sv | 63 ++++++
 rtl/rx_crc_serial.sv | 47 ++++
 rtl/rx_cmd_decoder.sv | 174 +++++++++++++++++
 tb/tb_rx_cmd_decoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_cmd_decoder_pkg.sv
// Shared definitions for the Gen2 command decoder: command codes,
// frame lengths, CRC constants and FSM encodings.
`timescale 1ns/1ps
package rx_cmd_decoder_pkg;

  localparam logic [2:0] CMD_QREP  = 3'd0;
  localparam logic [2:0] CMD_ACK   = 3'd1;
  localparam logic [2:0] CMD_QUERY = 3'd2;
  localparam logic [2:0] CMD_QADJ  = 3'd3;
  localparam logic [2:0] CMD_NAK   = 3'd4;
  localparam logic [2:0] CMD_REQRN = 3'd5;

  localparam logic [5:0] LEN_QREP  = 6'd4;
  localparam logic [5:0] LEN_ACK   = 6'd18;
  localparam logic [5:0] LEN_QUERY = 6'd22;
  localparam logic [5:0] LEN_QADJ  = 6'd9;
  localparam logic [5:0] LEN_NAK   = 6'd8;
  localparam logic [5:0] LEN_REQRN = 6'd40;

  localparam logic [5:0] PFX_SHORT = 6'd2;
  localparam logic [5:0] PFX_MID   = 6'd4;
  localparam logic [5:0] PFX_LONG  = 6'd8;

  localparam logic [4:0]  CRC5_PRESET   = 5'b01001;
  localparam logic [4:0]  CRC5_POLY     = 5'b01001;
  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_PAYLOAD,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic [5:0] cmd_len(input logic [2:0] c);
    logic [5:0] l;
    case (c)
      CMD_QREP:  l = LEN_QREP;
      CMD_ACK:   l = LEN_ACK;
      CMD_QUERY: l = LEN_QUERY;
      CMD_QADJ:  l = LEN_QADJ;
      CMD_NAK:   l = LEN_NAK;
      CMD_REQRN: l = LEN_REQRN;
      default:   l = LEN_NAK;
    endcase
    return l;
  endfunction

  // Last bit index that still belongs to the payload (CRC bits follow it).
  function automatic logic [5:0] pay_end(input logic [2:0] c);
    logic [5:0] l;
    case (c)
      CMD_QUERY: l = LEN_QUERY - 6'd5;
      CMD_REQRN: l = LEN_REQRN - 6'd16;
      default:   l = cmd_len(c);
    endcase
    return l;
  endfunction

endpackage

// File: rtl/rx_crc_serial.sv
// Serial CRC5 + CRC16 (MSB-first) with preset and shift enable.
// The *_nxt outputs show the value after shifting in din this cycle.
`timescale 1ns/1ps
module rx_crc_serial
  import rx_cmd_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        shift,
  input  logic        din,
  output logic [4:0]  crc5_nxt,
  output logic [15:0] crc16_nxt
);

  logic [4:0]  crc5_q, crc5_d, crc5_base;
  logic [15:0] crc16_q, crc16_d, crc16_base;

  always_comb begin
    crc5_base  = init ? CRC5_PRESET : crc5_q;
    crc16_base = init ? CRC16_PRESET : crc16_q;
    crc5_nxt   = {crc5_base[3:0], 1'b0}
               ^ ((crc5_base[4] ^ din) ? CRC5_POLY : 5'd0);
    crc16_nxt  = {crc16_base[14:0], 1'b0}
               ^ ((crc16_base[15] ^ din) ? CRC16_POLY : 16'd0);
    crc5_d     = crc5_q;
    crc16_d    = crc16_q;
    if (shift) begin
      crc5_d  = crc5_nxt;
      crc16_d = crc16_nxt;
    end else if (init) begin
      crc5_d  = crc5_base;
      crc16_d = crc16_base;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc5_q  <= CRC5_PRESET;
      crc16_q <= CRC16_PRESET;
    end else begin
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
    end
  end

endmodule

// File: rtl/rx_cmd_decoder.sv
// Splits the demodulated rx bit stream into Gen2 commands, captures
// their fields, checks CRC and pulses once per command or error.
`timescale 1ns/1ps
module rx_cmd_decoder
  import rx_cmd_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bitout,
  input  logic        bitclk,
  input  logic        frame_reset,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [15:0] payload,
  output logic        crc_ok,
  output logic        cmd_err
);

  state_t      state_q, state_d;
  logic        bitclk_q;
  logic        strobe;
  logic [5:0]  cnt_q, cnt_d, n;
  logic [7:0]  pfx_q, pfx_d, pfx_nx;
  logic [15:0] sh_q, sh_d;
  logic [2:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        ok_q, ok_d, ok_chk;
  logic [2:0]  ccode_q, ccode_d;
  logic [15:0] pay_q, pay_d;
  logic        crc_init, crc_shift, done;
  logic [4:0]  crc5_nxt;
  logic [15:0] crc16_nxt;

  rx_crc_serial u_crc (
    .clk       (clk),
    .reset     (reset),
    .init      (crc_init),
    .shift     (crc_shift),
    .din       (bitout),
    .crc5_nxt  (crc5_nxt),
    .crc16_nxt (crc16_nxt)
  );

  always_comb begin
    strobe    = bitclk & ~bitclk_q;
    n         = cnt_q + 6'd1;
    pfx_nx    = {pfx_q[6:0], bitout};
    state_d   = state_q;
    cnt_d     = cnt_q;
    pfx_d     = pfx_q;
    sh_d      = sh_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    ccode_d   = ccode_q;
    pay_d     = pay_q;
    ok_d      = ok_q;
    ok_chk    = 1'b1;
    crc_init  = 1'b0;
    crc_shift = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      // DONE lasts one cycle; a bit landing there opens the next frame
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        pfx_d   = '0;
        sh_d    = '0;
        if (strobe && !frame_reset) begin
          state_d   = ST_PREFIX;
          cnt_d     = 6'd1;
          pfx_d     = {7'd0, bitout};
          crc_init  = 1'b1;
          crc_shift = 1'b1;
        end
      end
      ST_PREFIX: begin
        if (frame_reset) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (strobe) begin
          cnt_d     = n;
          pfx_d     = pfx_nx;
          crc_shift = 1'b1;
          if (n == PFX_SHORT && !pfx_nx[1]) begin
            code_d  = pfx_nx[0] ? CMD_ACK : CMD_QREP;
            state_d = ST_PAYLOAD;
          end else if (n == PFX_MID && pfx_nx[3:2] == 2'b10) begin
            if (pfx_nx[1]) begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end else begin
              code_d  = pfx_nx[0] ? CMD_QADJ : CMD_QUERY;
              state_d = ST_PAYLOAD;
            end
          end else if (n == PFX_LONG) begin
            if (pfx_nx[7:1] != 7'b1100000) begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end else if (pfx_nx[0]) begin
              code_d  = CMD_REQRN;
              state_d = ST_PAYLOAD;
            end else begin
              code_d  = CMD_NAK;
              done    = 1'b1;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        if (frame_reset) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (strobe) begin
          cnt_d     = n;
          crc_shift = 1'b1;
          if (n <= pay_end(code_q)) sh_d = {sh_q[14:0], bitout};
          if (n == cmd_len(code_q)) done = 1'b1;
        end
      end
      ST_ERR: begin
        if (frame_reset) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (code_d == CMD_QUERY) ok_chk = (crc5_nxt == 5'd0);
    else if (code_d == CMD_REQRN) ok_chk = (crc16_nxt == CRC16_RESIDUE);

    if (done) begin
      state_d = ST_DONE;
      valid_d = 1'b1;
      ccode_d = code_d;
      pay_d   = sh_d;
      ok_d    = ok_chk;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bitclk_q <= 1'b0;
      cnt_q    <= '0;
      pfx_q    <= '0;
      sh_q     <= '0;
      code_q   <= CMD_QREP;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ccode_q  <= '0;
      pay_q    <= '0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitclk_q <= bitclk;
      cnt_q    <= cnt_d;
      pfx_q    <= pfx_d;
      sh_q     <= sh_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      ccode_q  <= ccode_d;
      pay_q    <= pay_d;
      ok_q     <= ok_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_err   = err_q;
  assign cmd_code  = ccode_q;
  assign payload   = pay_q;
  assign crc_ok    = ok_q;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Bench for rx_cmd_decoder: frame table plus hand-written corner
// sequences, checked through an expected-event queue.
`timescale 1ns/1ps
module tb_rx_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bitout = 1'b0;
  logic        bitclk = 1'b0;
  logic        frame_reset = 1'b0;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [15:0] payload;
  logic        crc_ok;
  logic        cmd_err;

  typedef struct packed {
    logic        err;
    logic [2:0]  code;
    logic [15:0] pay;
    logic        ok;
  } exp_t;

  typedef struct {
    logic [39:0] bits;
    int          n;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[11];
  exp_t got;
  int   nchk = 0;
  int   nfail = 0;
  int   npush = 0;
  int   npulse = 0;
  int   cyc = 0;
  int   last_evt = 0;

  rx_cmd_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .bitout      (bitout),
    .bitclk      (bitclk),
    .frame_reset (frame_reset),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .payload     (payload),
    .crc_ok      (crc_ok),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic e, input logic [2:0] c,
                              input logic [15:0] p, input logic o);
    exp_t r;
    r.err  = e;
    r.code = c;
    r.pay  = p;
    r.ok   = o;
    return r;
  endfunction

  function automatic logic [4:0] gold_crc5(input logic [39:0] b, input int n);
    logic [4:0] c;
    logic fb;
    c = 5'b01001;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[4] ^ b[i];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'b01001;
    end
    return c;
  endfunction

  function automatic logic [15:0] gold_crc16(input logic [39:0] b, input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return ~c;
  endfunction

  task automatic send_bit(input logic b, input logic fr);
    @(negedge clk);
    bitout      = b;
    bitclk      = 1'b1;
    frame_reset = fr;
    last_evt    = cyc + 1;
    @(negedge clk);
    frame_reset = 1'b0;
    @(negedge clk);
    bitclk = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [39:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(b[i], 1'b0);
  endtask

  task automatic pulse_fr();
    @(negedge clk);
    frame_reset = 1'b1;
    last_evt    = cyc + 1;
    @(negedge clk);
    frame_reset = 1'b0;
  endtask

  task automatic expect_ev(input exp_t e);
    sb.push_back(e);
    npush++;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    nchk++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Scoreboard: every pulse must match the oldest expected event and
  // arrive one clock after its deciding strobe or frame_reset.
  always @(negedge clk) begin
    if (!reset && (cmd_valid || cmd_err)) begin
      npulse++;
      nchk++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b code=%0d pay=%h",
                 cmd_valid, cmd_err, cmd_code, payload);
      end else begin
        got = sb.pop_front();
        if (cyc != last_evt || cmd_err != got.err || cmd_valid == got.err ||
            (!got.err && (cmd_code != got.code || payload != got.pay ||
                          crc_ok != got.ok))) begin
          nfail++;
          $display("FAIL cmd_event: got err=%0b valid=%0b code=%0d pay=%h ok=%0b cyc=%0d want err=%0b code=%0d pay=%h ok=%0b cyc=%0d",
                   cmd_err, cmd_valid, cmd_code, payload, crc_ok, cyc,
                   got.err, got.code, got.pay, got.ok, last_evt);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [16:0] q0, q1;
    logic [23:0] r0, r1;
    logic [39:0] ack;

    q0 = {4'b1000, 13'h0000};
    q1 = {4'b1000, 13'h1A5B};
    r0 = {8'b11000001, 16'h1234};
    r1 = r0 ^ 24'd1;

    tbl[0]  = '{{22'd0, 2'b01, 16'hA5C3}, 18, mk(0, 3'd1, 16'hA5C3, 1)};
    tbl[1]  = '{{36'd0, 4'b0010}, 4, mk(0, 3'd0, 16'h0002, 1)};
    tbl[2]  = '{{18'd0, q0, gold_crc5({23'd0, q0}, 17)}, 22,
                mk(0, 3'd2, 16'h0000, 1)};
    tbl[3]  = '{tbl[2].bits ^ 40'd1, 22, mk(0, 3'd2, 16'h0000, 0)};
    tbl[4]  = '{{r0, gold_crc16({16'd0, r0}, 24)}, 40,
                mk(0, 3'd5, 16'h1234, 1)};
    tbl[5]  = '{{r1, gold_crc16({16'd0, r0}, 24)}, 40,
                mk(0, 3'd5, 16'h1235, 0)};
    tbl[6]  = '{{31'd0, 9'b1001_10110}, 9, mk(0, 3'd3, 16'h0016, 1)};
    tbl[7]  = '{{32'd0, 8'b11000000}, 8, mk(0, 3'd4, 16'h0000, 1)};
    tbl[8]  = '{{18'd0, q1, gold_crc5({23'd0, q1}, 17)}, 22,
                mk(0, 3'd2, 16'h1A5B, 1)};
    tbl[9]  = '{{32'd0, 8'b11100000}, 8, mk(1, 3'd0, 16'h0000, 0)};
    tbl[10] = '{{36'd0, 4'b1011}, 4, mk(1, 3'd0, 16'h0000, 0)};

    idle(3);
    check("reset_outputs",
          {11'd0, cmd_valid, cmd_code, payload, crc_ok, cmd_err}, 32'd0);
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < 11; i++) begin
      expect_ev(tbl[i].e);
      send_bits(tbl[i].bits, tbl[i].n);
      idle(3);
      pulse_fr();
      idle(2);
    end

    // Unsupported prefix: one error, then silence until frame_reset.
    expect_ev(mk(1, 3'd0, 16'h0000, 0));
    send_bits({36'd0, 4'b1010}, 4);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    idle(3);
    check("err_silence", npulse, npush);
    pulse_fr();
    idle(2);
    ack = {22'd0, 2'b01, 16'hA5C3};
    expect_ev(mk(0, 3'd1, 16'hA5C3, 1));
    send_bits(ack, 18);
    idle(3);

    // Truncated ACK: error pulse, held outputs untouched.
    ack = {22'd0, 2'b01, 16'h5A3C};
    send_bits(ack >> 8, 10);
    expect_ev(mk(1, 3'd0, 16'h0000, 0));
    pulse_fr();
    idle(3);
    check("held_after_trunc", {12'd0, cmd_code, payload, crc_ok},
          {12'd0, 3'd1, 16'hA5C3, 1'b1});

    // frame_reset coincident with a strobe drops that bit.
    send_bit(1'b1, 1'b1);
    expect_ev(mk(0, 3'd0, 16'h0002, 1));
    send_bits({36'd0, 4'b0010}, 4);
    idle(3);

    // Async reset mid-frame clears outputs immediately.
    send_bits(ack >> 13, 5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs",
          {11'd0, cmd_valid, cmd_code, payload, crc_ok, cmd_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    expect_ev(mk(0, 3'd1, 16'h5A3C, 1));
    send_bits(ack, 18);
    idle(10);

    check("queue_drained", sb.size(), 32'd0);
    check("pulse_count", npulse, npush);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
